// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: ST7735 byte-level SPI mode-0 transmitter with a one-cycle wr_done per byte.
// Optional macro LCD_SPI_WRITER_CS_HOLD_EN keeps CS asserted across a burst of back-to-back bytes.
module lcd_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int GAP     = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_TC = 4'(GAP);

`ifdef LCD_SPI_WRITER_CS_HOLD_EN
  localparam bit CS_HOLD = 1'b1;
`else
  localparam bit CS_HOLD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t     state_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [3:0] gap_q;
  logic [6:0] shreg_q;
  logic       wr_done_q;
  logic       cs_n_q;
  logic       dc_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       tick;

  // The LOAD cycle counts as divider slot 0, so the first SCLK rise lands CLK_DIV cycles after bit 7.
  assign tick = ((state_q == S_SHIFT) && (div_q == DIV_TC)) ||
                ((state_q == S_LOAD) && (CLK_DIV == 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      wr_done_q <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      gap_q     <= 4'd0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_write) begin
            shreg_q <= data[6:0];
            mosi_q  <= data[7];
            dc_q    <= data[8];
            cs_n_q  <= 1'b0;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            state_q <= S_LOAD;
          end else begin
            cs_n_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          div_q   <= (CLK_DIV == 1) ? 8'd0 : 8'd1;
          if (tick) sclk_q <= ~sclk_q;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tick) begin
            div_q  <= 8'd0;
            sclk_q <= ~sclk_q;
            // Falling edge: present the next bit while SCLK is low.
            if (sclk_q) begin
              shreg_q <= {shreg_q[5:0], 1'b0};
              mosi_q  <= shreg_q[6];
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= S_DONE;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        S_DONE: begin
          wr_done_q <= 1'b1;
          if (!CS_HOLD) cs_n_q <= 1'b1;
          gap_q     <= 4'd0;
          state_q   <= S_GAP;
        end
        S_GAP: begin
          // Gap counts from the wr_done cycle so upstream can settle its next word.
          if (gap_q == GAP_TC) state_q <= S_IDLE;
          else                 gap_q   <= gap_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_done  = wr_done_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_dc   = dc_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;

endmodule

// File: doc/lcd_spi_writer.md
# lcd_spi_writer

Byte-level SPI transmitter for the ST7735 panel, directly downstream of the character and window command sources. Consumes a 9-bit command/data word plus a write-enable level, shifts the low byte out MSB-first in SPI mode 0 with the D/C line taken from bit 8, and returns a one-cycle `wr_done` per byte. Upstream stages advance their sequence counters on that pulse. This block owns the panel's CS, DC, SCLK and MOSI pins.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `sys_clk` cycles; legal range 1..255.
- `GAP`, default 4: idle cycles after `wr_done` before `en_write` is sampled again; legal range 2..15.
- `sys_clk` in 1: the only clock. Everything is on the rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `en_write` in 1: level request. While high in IDLE, a byte is started.
- `data` in 9: bit 8 is D/C (0 = command, 1 = data); bits 7:0 are the payload.
- `wr_done` out 1: one-cycle pulse when a byte has fully shifted out.
- `lcd_cs_n` out 1: chip select, active low.
- `lcd_dc` out 1: data/command select.
- `lcd_sclk` out 1: SPI clock, idles low.
- `lcd_mosi` out 1: serial data, MSB first.

## Operation
- States: IDLE, LOAD, SHIFT, DONE, GAP.
- IDLE:
  - If `en_write` is high, go to LOAD. Otherwise stay.
  - `data` is sampled only on this edge.
- LOAD (1 cycle):
  - Latch `data[7:0]` into the shift register and `data[8]` into `lcd_dc`.
  - Drive `lcd_cs_n` low and put bit 7 on `lcd_mosi`.
  - Go to SHIFT.
- SHIFT:
  - A divider counts 0..CLK_DIV-1.
  - At each terminal count, `lcd_sclk` toggles.
  - On each falling edge, shift left and present the next bit.
  - A 3-bit bit counter runs 0..7. After the 8th falling edge, go to DONE.
  - Changes on `data` or `en_write` during the byte are ignored. A byte, once started, always completes and always produces `wr_done`.
- DONE (1 cycle):
  - `wr_done` = 1.
  - `lcd_cs_n` returns high (see Configuration).
  - Go to GAP.
- GAP:
  - Count GAP cycles, then go to IDLE.
  - This guarantees upstream has registered its next word and updated `en_write` before resampling. Upstream updates up to 3 cycles after `wr_done`.
- Reset values:
  - state IDLE
  - `wr_done` = 0, `lcd_cs_n` = 1, `lcd_dc` = 0, `lcd_sclk` = 0, `lcd_mosi` = 0
  - divider, bit and gap counters = 0
- Reset mid-byte: outputs take their reset values on the next edge. The partial byte is abandoned and no `wr_done` is issued.
- `lcd_sclk` must never glitch. It only changes on divider terminal count or reset.

## Timing
- Let edge 0 be the edge on which IDLE samples `en_write` = 1.
- `lcd_cs_n` low, `lcd_dc` and bit 7 valid: from after edge 0 (cycle 1).
- First SCLK rise: CLK_DIV cycles after bit 7 is presented. MOSI is stable for CLK_DIV cycles on either side of every rising edge.
- `wr_done` is high during cycle 2 + 16·CLK_DIV.
- Next sampling edge: 3 + 16·CLK_DIV + GAP. With defaults this is 39, which is the back-to-back byte period.
- `lcd_sclk` is low in IDLE, LOAD, DONE and GAP.

## Configuration
- `LCD_SPI_WRITER_CS_HOLD_EN` defined:
  - `lcd_cs_n` stays low through DONE and GAP.
  - It is released in IDLE only if `en_write` is low, giving continuous CS across a command burst.
- Not defined: `lcd_cs_n` goes high in DONE and stays high through GAP and IDLE, so every byte is individually framed.

## Test plan
- **Reset:** assert `sys_rst` for 2 cycles.
  - Outputs take their reset values, including `lcd_cs_n` = 1 and `lcd_sclk` = 0.
  - No `wr_done`.
- **Single command, defaults:** `data` = 9'h02A, `en_write` pulsed high for 1 cycle.
  - `lcd_dc` = 0.
  - MOSI sampled on the 8 SCLK rises = 0,0,1,0,1,0,1,0.
  - `wr_done` high only at cycle 34.
- **Back-to-back data:** hold `en_write` high; after each `wr_done`, change `data` 3 cycles later, sequencing 9'h1F8 then 9'h100.
  - Two bytes are sent: 0xF8, then 0x00, each with DC = 1.
  - Sampling edges at cycles 0 and 39.
- **Mid-byte changes:** drop `en_write` and change `data` at cycle 10.
  - The byte completes with the originally latched value.
  - `wr_done` at cycle 34; no second byte.
- **Reset mid-byte:** assert `sys_rst` at cycle 20.
  - Outputs are at reset values from cycle 21.
  - No `wr_done` is ever produced for that byte.
- **CLK_DIV = 1, both macro settings:** two bytes back-to-back.
  - `wr_done` at cycles 18 and 41.
  - With the macro, `lcd_cs_n` stays low from cycle 1 through the second byte.
  - Without it, `lcd_cs_n` is high during cycles 18–23.
